// File: rtl/staff_fb_pkg.sv
// Shared constants, FSM state type and word-address helper for the staff framebuffer.
package staff_fb_pkg;

    localparam int ROWS   = 480;
    localparam int COLS   = 20;
    localparam int DIM    = ROWS * COLS;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, ACK, CLR} fb_state_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [9:0] y, input logic [4:0] col);
        return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/staff_vid_prefetch.sv
// Video side: group-start detect, next-word slot address, double-buffered word and pixel out.
module staff_vid_prefetch
    import staff_fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [31:0]       mem_rdata,
    output logic              slot,
    output logic [ADDR_W-1:0] slot_addr,
    output logic              draw_bck
);

    logic [4:0]  prev_lo;
    logic        slot_d;
    logic [31:0] prefetch;
    logic [31:0] vid_word;
    logic [9:0]  next_row;
    logic [4:0]  next_col;

    assign slot = (DrawX[4:0] == 5'd0) && (prev_lo != 5'd0);

    // Past the last visible group (and through blanking) fetch column 0 of the next row.
    always_comb begin
        next_row = DrawY;
        next_col = DrawX[9:5] + 5'd1;
        if (DrawX >= 10'd608) begin
            next_row = (DrawY < 10'd479) ? DrawY + 10'd1 : 10'd0;
            next_col = 5'd0;
        end
    end

    assign slot_addr = word_addr(next_row, next_col);
    assign draw_bck  = vid_word[~DrawX[4:0]];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_lo  <= 5'd0;
            slot_d   <= 1'b0;
            prefetch <= 32'd0;
            vid_word <= 32'd0;
        end else begin
            prev_lo <= DrawX[4:0];
            slot_d  <= slot;
            if (slot_d) prefetch <= mem_rdata;
            if (slot)   vid_word <= prefetch;
        end
    end

endmodule

// File: rtl/staff_fb_arbiter.sv
// Framebuffer RAM arbiter: video slots win, pixel writer does read-modify-write around them.
// Optional full-buffer clear is built when STAFF_FB_CLEAR_EN is defined.
module staff_fb_arbiter
    import staff_fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              draw_bck,
    input  logic              pix_req,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_val,
    output logic              pix_ack,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    fb_state_t         state;
    logic [9:0]        px, py;
    logic              pv;
    logic [31:0]       rmw, merged;
    logic              slot;
    logic [ADDR_W-1:0] slot_addr, pix_addr;

    staff_vid_prefetch u_vid (
        .Clk       (Clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .mem_rdata (mem_rdata),
        .slot      (slot),
        .slot_addr (slot_addr),
        .draw_bck  (draw_bck)
    );

    assign pix_addr = word_addr(py, px[9:5]);

    always_comb begin
        merged             = rmw;
        merged[~px[4:0]]   = pv;
    end

`ifdef STAFF_FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    assign clr_busy = (state == CLR);
`else
    logic unused_clr;
    assign unused_clr = clr_req;
    assign clr_busy   = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            px    <= 10'd0;
            py    <= 10'd0;
            pv    <= 1'b0;
            rmw   <= 32'd0;
`ifdef STAFF_FB_CLEAR_EN
            clr_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef STAFF_FB_CLEAR_EN
                    if (clr_req) begin
                        state   <= CLR;
                        clr_cnt <= '0;
                    end else
`endif
                    if (pix_req) begin
                        px    <= pix_x;
                        py    <= pix_y;
                        pv    <= pix_val;
                        state <= (pix_x >= 10'd640 || pix_y >= 10'(ROWS)) ? ACK : RD;
                    end
                end
                RD:   if (!slot) state <= WAIT;
                WAIT: begin
                    rmw   <= mem_rdata;
                    state <= WR;
                end
                WR:   if (!slot) state <= IDLE;
                ACK:  state <= IDLE;
`ifdef STAFF_FB_CLEAR_EN
                CLR: if (!slot) begin
                    if (clr_cnt == ADDR_W'(DIM - 1)) state <= IDLE;
                    else clr_cnt <= clr_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // A slot owns the RAM port outright; writer steps scheduled on it simply repeat next cycle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        pix_ack   = (state == ACK);
        if (slot) begin
            mem_addr = slot_addr;
        end else begin
            case (state)
                RD: mem_addr = pix_addr;
                WR: begin
                    mem_addr  = pix_addr;
                    mem_we    = 1'b1;
                    mem_wdata = merged;
                    pix_ack   = 1'b1;
                end
`ifdef STAFF_FB_CLEAR_EN
                CLR: begin
                    mem_addr = clr_cnt;
                    mem_we   = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_staff_fb_arbiter.sv
// Directed bench for staff_fb_arbiter with a 1-cycle-latency RAM model.
module tb_staff_fb_arbiter;

    logic        Clk, Reset;
    logic [9:0]  DrawX, DrawY;
    logic        draw_bck;
    logic        pix_req, pix_val, pix_ack;
    logic [9:0]  pix_x, pix_y;
    logic        clr_req, clr_busy;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    bit   [31:0] ram [0:16383];
    logic        bd_we;
    logic [13:0] bd_addr;
    logic [31:0] bd_data;
    int          wr_cnt, clr_wr, ack_cnt;
    int          n_chk, n_fail;
    int          snap_wr, snap_ack;

    staff_fb_arbiter dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .draw_bck(draw_bck),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val), .pix_ack(pix_ack),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (mem_we && clr_busy && mem_wdata == 32'd0) clr_wr <= clr_wr + 1;
        if (pix_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [13:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        cyc();
        bd_we = 1'b0;
    endtask

    task automatic req(input logic [9:0] x, input logic [9:0] y, input logic v);
        pix_req = 1'b1; pix_x = x; pix_y = y; pix_val = v;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        wr_cnt = 0; clr_wr = 0; ack_cnt = 0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        pix_req = 1'b0; pix_x = 10'd0; pix_y = 10'd0; pix_val = 1'b0; clr_req = 1'b0;
        repeat (3) cyc();
        chk("rst_we", mem_we, 1'b0);
        chk("rst_ack", pix_ack, 1'b0);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_bck", draw_bck, 1'b0);
        chk("rst_addr", mem_addr, 14'd0);
        bd_write(14'd0, 32'h8000_0001);
        bd_write(14'd3, 32'hA5A5_0000);

        // Row 479 tail -> wrap fetch of word 0, displayed from row 0 group 0
        DrawY = 10'd479; DrawX = 10'd607; Reset = 1'b0;
        cyc();
        DrawX = 10'd608; #1;
        chk("wrap_addr", mem_addr, 14'd0);
        chk("wrap_we", mem_we, 1'b0);
        cyc();
        chk("first_pass", draw_bck, 1'b0);
        cyc();
        DrawX = 10'd639;
        cyc();
        DrawY = 10'd0; DrawX = 10'd0;
        cyc();
        chk("bck_x0", draw_bck, 1'b1);
        DrawX = 10'd15; #1;
        chk("bck_x15", draw_bck, 1'b0);
        DrawX = 10'd31; #1;
        chk("bck_x31", draw_bck, 1'b1);
        cyc();

        // Slot addresses mid-frame
        DrawY = 10'd10; DrawX = 10'd607;
        cyc();
        DrawX = 10'd608; #1;
        chk("slot_row10", mem_addr, 14'd220);
        cyc();
        DrawX = 10'd63;
        cyc();
        DrawX = 10'd64; #1;
        chk("slot_col3", mem_addr, 14'd203);
        cyc();

        // Uncontended RMW of (37,2) into a zero word
        DrawY = 10'd0; DrawX = 10'd69;
        cyc();
        req(10'd37, 10'd2, 1'b1); #1;
        chk("w_idle_ack", pix_ack, 1'b0);
        cyc();
        chk("w_rd_addr", mem_addr, 14'd41);
        chk("w_rd_we", mem_we, 1'b0);
        cyc();
        chk("w_wait_ack", pix_ack, 1'b0);
        cyc();
        chk("w_wr_we", mem_we, 1'b1);
        chk("w_wr_addr", mem_addr, 14'd41);
        chk("w_wr_data", mem_wdata, 32'h0400_0000);
        chk("w_wr_ack", pix_ack, 1'b1);
        pix_req = 1'b0;
        cyc();
        chk("w_post_ack", pix_ack, 1'b0);
        chk("w_ram41", ram[41], 32'h0400_0000);

        // Same request with a slot landing on RD; word merges with existing bits
        bd_write(14'd41, 32'h0000_00F0);
        DrawX = 10'd63;
        cyc();
        req(10'd37, 10'd2, 1'b1);
        cyc();
        DrawX = 10'd64; #1;
        chk("c_slot_addr", mem_addr, 14'd3);
        chk("c_slot_we", mem_we, 1'b0);
        cyc();
        chk("c_rd_retry", mem_addr, 14'd41);
        cyc();
        chk("c_wait_ack", pix_ack, 1'b0);
        cyc();
        chk("c_wr_data", mem_wdata, 32'h0400_00F0);
        chk("c_wr_ack", pix_ack, 1'b1);
        pix_req = 1'b0;
        cyc();
        chk("c_ram41", ram[41], 32'h0400_00F0);
        DrawX = 10'd95;
        cyc();
        DrawX = 10'd96;
        cyc();
        chk("c_vid_b31", draw_bck, 1'b1);
        DrawX = 10'd97; #1;
        chk("c_vid_b30", draw_bck, 1'b0);
        DrawX = 10'd98; #1;
        chk("c_vid_b29", draw_bck, 1'b1);

        // Out-of-range requests ack in one cycle with no RAM access
        DrawX = 10'd101;
        cyc();
        snap_wr = wr_cnt;
        req(10'd700, 10'd2, 1'b1);
        cyc();
        chk("oor_x_ack", pix_ack, 1'b1);
        chk("oor_x_we", mem_we, 1'b0);
        cyc();
        chk("oor_no_resample", pix_ack, 1'b0);
        pix_req = 1'b0;
        cyc();
        req(10'd5, 10'd480, 1'b1);
        cyc();
        chk("oor_y_ack", pix_ack, 1'b1);
        pix_req = 1'b0;
        cyc();
        chk("oor_no_write", wr_cnt, snap_wr);

        // Reset while in WAIT abandons the write
        req(10'd37, 10'd2, 1'b0);
        cyc();
        cyc();
        Reset = 1'b1; #1;
        chk("rw_we", mem_we, 1'b0);
        chk("rw_ack", pix_ack, 1'b0);
        chk("rw_addr", mem_addr, 14'd0);
        pix_req = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
        cyc();
        chk("rw_no_write", wr_cnt, snap_wr);
        chk("rw_ram41", ram[41], 32'h0400_00F0);
        chk("rw_bck", draw_bck, 1'b0);

        // Clearing a single bit
        req(10'd37, 10'd2, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("clrbit_data", mem_wdata, 32'h0000_00F0);
        chk("clrbit_ack", pix_ack, 1'b1);
        pix_req = 1'b0;
        cyc();

`ifdef STAFF_FB_CLEAR_EN
        bd_write(14'd9599, 32'h0000_0001);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        chk("clr_busy_rise", clr_busy, 1'b1);
        snap_ack = ack_cnt;
        req(10'd1, 10'd1, 1'b1);
        for (int i = 0; i < 12000 && clr_busy; i++) begin
            DrawX = (DrawX == 10'd799) ? 10'd0 : DrawX + 10'd1;
            if (DrawX == 10'd0) DrawY = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
            cyc();
        end
        pix_req = 1'b0;
        chk("clr_done", clr_busy, 1'b0);
        chk("clr_writes", clr_wr, 9600);
        chk("clr_no_ack", ack_cnt, snap_ack);
        chk("clr_ram9599", ram[9599], 32'd0);
        chk("clr_ram41", ram[41], 32'd0);
        cyc();
`else
        snap_wr = wr_cnt;
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        chk("noclr_busy", clr_busy, 1'b0);
        chk("noclr_we", mem_we, 1'b0);
        cyc();
        chk("noclr_writes", wr_cnt, snap_wr);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/staff_fb_arbiter.md
# staff_fb_arbiter

Arbiter and sequencer for the 1-bit-per-pixel staff framebuffer, a 640×480 image stored as 9600 words of 32 bits in a single-port synchronous RAM. The video scan reader has hard priority: it gets one read slot per 32-pixel group and its words are prefetched and double-buffered. A pixel writer, the note-drawing engine, uses every other cycle through a read-modify-write state machine. The block sits between the VGA controller / colour mapper and the framebuffer RAM, and drives `draw_bck` for the colour mapper.

## Interface
Parameters:
- `ROWS`, 480: visible lines.
- `COLS`, 20: 32-bit words per line.
- `DIM`, `ROWS*COLS`: total number of words.
- `ADDR_W`, 14: RAM address width.

Ports:
- `Clk`, in, 1: the single clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `DrawX`, `DrawY`, in, 10 each: current scan position; may advance at most once per `Clk`.
- `draw_bck`, out, 1: background pixel at the current `DrawX`.
- `pix_req`, in, 1: pixel write request; held together with its operands until `pix_ack`.
- `pix_x`, `pix_y`, in, 10 each: coordinates of the pixel to write.
- `pix_val`, in, 1: value to write (1 sets the pixel, 0 clears it).
- `pix_ack`, out, 1: one-cycle pulse when the request completes.
- `clr_req`, in, 1: pulse that starts a full-buffer clear.
- `clr_busy`, out, 1: high while a clear is in progress.
- `mem_addr`, out, `ADDR_W`: RAM address; RAM read latency is 1 cycle.
- `mem_we`, out, 1: RAM write enable.
- `mem_wdata`, out, 32: RAM write data.
- `mem_rdata`, in, 32: RAM read data.

## Operation
- Word address is `20*y + x[9:5]`. Within a word the pixel bit is `31 - x[4:0]`, so the MSB is the leftmost pixel.
- A group start occurs on the cycle `DrawX[4:0]` becomes 0, i.e. it differs from the previous cycle's value.
- On a group start:
  - `vid_word <= prefetch`.
  - A video slot is issued for the next visible word:
    - same row, column `DrawX[9:5]+1`, when `DrawX < 608`;
    - otherwise column 0 of the next row. The next row is `DrawY+1` if `DrawY < 479`, else row 0.
- On the cycle after a slot, `prefetch <= mem_rdata`.
- `draw_bck = vid_word[31 - DrawX[4:0]]`, combinational.
- During a slot cycle `mem_addr` is the video address and `mem_we = 0`. Any writer step scheduled for that cycle stalls by one cycle.
- Writer FSM states:
  - IDLE: on `pix_req`, capture the operands. If `pix_x ≥ 640` or `pix_y ≥ 480`, go to ACK; otherwise go to RD.
  - RD: drive the address. If this is not a slot cycle, go to WAIT; else stay in RD.
  - WAIT: capture `mem_rdata` into `rmw`, then go to WR.
  - WR: if not a slot cycle, drive `mem_we = 1` with `rmw` having the target bit replaced by `pix_val`, pulse `pix_ack`, and go to IDLE.
  - ACK: pulse `pix_ack` (no memory access), then go to IDLE.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from the FSM state and slot, and are 0 when idle.
- A write may hit a word that has already been prefetched. That word then displays stale for at most one group. This is accepted behaviour.
- Reset, including mid-RMW:
  - FSM goes to IDLE and the partial write is abandoned.
  - `vid_word`, `prefetch`, `pix_ack` and `clr_busy` are 0.
  - `mem_we` is 0 during and after reset.

## Timing
- Uncontended write: req sampled in IDLE at cycle 0; RD at cycle 1; WAIT at cycle 2; WR with `mem_we` and `pix_ack` at cycle 3.
- Out-of-range write: `pix_ack` at cycle 1 with no RAM access.
- Each slot collision adds exactly 1 cycle.
- Video fetch: address at the group start cycle, `prefetch` valid 2 cycles later. The word is displayed from the next group start.
- The first group after reset displays zeros.
- `pix_req` seen in the same cycle as an ack'd completion is not re-sampled until the following IDLE cycle.

## Configuration
- `STAFF_FB_CLEAR_EN` defined:
  - A CLR state exists. A `clr_req` pulse seen in IDLE enters CLR and raises `clr_busy`.
  - CLR writes 0 to addresses 0…9599, one per non-slot cycle.
  - After address 9599, `clr_busy` falls and the FSM returns to IDLE.
  - `pix_req` is held off, with no ack, while busy.
  - `clr_req` arriving while the FSM is not in IDLE is ignored.
- `STAFF_FB_CLEAR_EN` not defined: `clr_req` is ignored, `clr_busy` is tied to 0, and no CLR state exists.

## Structure
- `staff_fb_pkg` holds:
  - `ROWS`, `COLS`, `DIM`, `ADDR_W`;
  - the `fb_state_t` enum (IDLE, RD, WAIT, WR, ACK, CLR);
  - a function for the word address.
- Sub-module `staff_vid_prefetch` contains:
  - group-start detect, next-word address generation and the slot strobe;
  - the `prefetch` and `vid_word` registers;
  - the `draw_bck` output.

## Test plan
- Reset, then scan row 0 with RAM word 0 = `0x8000_0001` → `draw_bck` = 1 at `DrawX` 0 and 31 in the second displayed pass; 0 elsewhere in that group.
- `pix_req` with (37, 2), `pix_val` 1 into a zero RAM → RMW on address 41 writes `0x0400_0000`; `pix_ack` at cycle 3.
- The same request with a slot landing on the RD cycle → RD held one cycle, ack at cycle 4, and the video read returns the correct word.
- `pix_x` = 700 → ack at cycle 1, `mem_we` never asserted.
- Scan position `DrawY` = 479, `DrawX` = 608 → slot fetches address 0; `DrawY` = 10, `DrawX` = 608 → slot fetches address 220.
- `Reset` asserted in WAIT → no write occurs, outputs return to 0. With `STAFF_FB_CLEAR_EN` defined, `clr_req` → 9600 zero writes interleaved with slots, then `clr_busy` falls.
